// File: rtl/ptn_loader_pkg.sv
// Shared sequencer constants: loader FSM state encodings and the default frame header byte.
package ptn_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHK    = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/ptn_idx_cnt.sv
// Entry index counter: synchronous clear to zero, increment, terminal flag at SEQ_CNT.
// Single-cycle update; clear wins over increment.
module ptn_idx_cnt #(
  parameter int BW_IDX  = 3,
  parameter int SEQ_CNT = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [BW_IDX-1:0] idx_o,
  output logic              last_o
);

  logic [BW_IDX-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == BW_IDX'(SEQ_CNT));

endmodule

// File: rtl/ptn_loader.sv
// Byte-stream pattern loader: HDR, SEQ_CNT+1 entry bytes, XOR checksum; commits PTN one cycle after the checksum byte.
// DIN_READY drops only for the single COMMIT cycle, so a held DIN_VALID stream loses no bytes.
module ptn_loader
  import ptn_loader_pkg::*;
#(
  parameter int         BW_SEQ     = 4,
  parameter int         BW_TIMEOUT = 2,
  parameter int         SEQ_CNT    = 7,
  parameter int         BW_IDX     = 3,
  parameter logic [7:0] HDR        = HDR_DEFAULT
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic [7:0]                               DIN,
  input  logic                                     DIN_VALID,
  output logic                                     DIN_READY,
  input  logic                                     ABORT,
  output logic [(BW_SEQ+BW_TIMEOUT)*(SEQ_CNT+1)-1:0] PTN,
  output logic                                     CLR,
  output logic                                     ERR,
  output logic                                     BUSY
);

  localparam int W = BW_SEQ + BW_TIMEOUT;

  state_e                   state_q, state_d;
  logic [SEQ_CNT:0][W-1:0]  shadow_q;
  logic [SEQ_CNT:0][W-1:0]  ptn_q;
  logic [7:0]               csum_q;
  logic                     clr_q, err_q;
  logic [BW_IDX-1:0]        idx;
  logic                     idx_last;
  logic                     acc, load_wr, commit_go, err_go, idx_clr;

  ptn_idx_cnt #(
    .BW_IDX  (BW_IDX),
    .SEQ_CNT (SEQ_CNT)
  ) u_idx_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (idx_clr),
    .inc_i  (load_wr),
    .idx_o  (idx),
    .last_o (idx_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (acc && DIN == HDR) state_d = ST_LOAD;
        ST_LOAD:   if (acc && idx_last)   state_d = ST_CHK;
        ST_CHK:    if (acc)               state_d = (DIN == csum_q) ? ST_COMMIT : ST_IDLE;
        ST_COMMIT:                        state_d = ST_IDLE;
        default:                          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    DIN_READY = (state_q != ST_COMMIT);
    BUSY      = (state_q != ST_IDLE);
    acc       = DIN_VALID && DIN_READY;
    load_wr   = (state_q == ST_LOAD) && acc && !ABORT;
    commit_go = (state_q == ST_CHK) && acc && !ABORT && (DIN == csum_q);
    err_go    = (state_q == ST_CHK) && acc && !ABORT && (DIN != csum_q);
    idx_clr   = ABORT || (state_q != ST_LOAD);
  end

  // PTN and CLR are registered on the checksum edge, so both are visible during COMMIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
      ptn_q    <= '0;
      csum_q   <= '0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clr_q <= commit_go;
      err_q <= err_go;
      if (ABORT || state_q == ST_IDLE) begin
        csum_q <= '0;
      end else if (load_wr) begin
        csum_q <= csum_q ^ DIN;
      end
      if (load_wr) begin
        shadow_q[idx] <= DIN[W-1:0];
      end
      if (commit_go) begin
        ptn_q <= shadow_q;
      end
    end
  end

  assign PTN = ptn_q;
  assign CLR = clr_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_ptn_loader.sv
// Directed bench for ptn_loader: good/bad frames, noise before header, abort, reset in CHK, back-to-back frames.
module tb_ptn_loader;

  logic        CLK;
  logic        RST;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic        ABORT;
  logic [47:0] PTN;
  logic        CLR;
  logic        ERR;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;
  int stall   = 0;
  int hdr_stall = 0;

  // Entry k is byte[5:0] at PTN[6k+5:6k].
  localparam logic [63:0] F1_DAT = 64'h0807060504030201;
  localparam logic [7:0]  F1_CS  = 8'h08;
  localparam logic [47:0] F1_PTN = 48'h207185103081;
  localparam logic [63:0] F2_DAT = 64'h7E80FFC12A15003F;
  localparam logic [7:0]  F2_CS  = 8'hC0;
  localparam logic [47:0] F2_PTN = 48'hF80FC1A9503F;
  localparam logic [63:0] F3_DAT = 64'h000000000000A5A5;
  localparam logic [7:0]  F3_CS  = 8'h00;
  localparam logic [47:0] F3_PTN = 48'h000000000965;

  ptn_loader dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .ABORT     (ABORT),
    .PTN       (PTN),
    .CLR       (CLR),
    .ERR       (ERR),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that accepted the byte.
  task automatic send(input logic [7:0] b, input bit keep);
    DIN       = b;
    DIN_VALID = 1'b1;
    stall     = 0;
    while (!DIN_READY && stall < 8) begin
      @(posedge CLK); #1;
      stall++;
    end
    if (!DIN_READY) chk("ready_timeout", 64'(DIN_READY), 64'd1);
    @(posedge CLK); #1;
    if (!keep) DIN_VALID = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [7:0] cs, input bit keep);
    send(8'hA5, keep);
    hdr_stall = stall;
    for (int i = 0; i < 8; i++) send(d[8*i +: 8], keep);
    send(cs, keep);
  endtask

  initial begin
    RST = 1'b1; DIN = 8'h00; DIN_VALID = 1'b0; ABORT = 1'b0;
    #3;
    chk("rst_ptn",   64'(PTN),       64'd0);
    chk("rst_clr",   64'(CLR),       64'd0);
    chk("rst_err",   64'(ERR),       64'd0);
    chk("rst_busy",  64'(BUSY),      64'd0);
    chk("rst_ready", 64'(DIN_READY), 64'd1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Good frame: CLR and new PTN in the cycle right after the checksum byte.
    send_frame(F1_DAT, F1_CS, 1'b0);
    chk("f1_clr",   64'(CLR),       64'd1);
    chk("f1_ptn",   64'(PTN),       64'(F1_PTN));
    chk("f1_err",   64'(ERR),       64'd0);
    chk("f1_ready", 64'(DIN_READY), 64'd0);
    chk("f1_busy",  64'(BUSY),      64'd1);
    @(posedge CLK); #1;
    chk("f1_clr_end",  64'(CLR),  64'd0);
    chk("f1_busy_end", 64'(BUSY), 64'd0);

    // Bad checksum: ERR pulse only, PTN kept.
    send_frame(F1_DAT, 8'h09, 1'b0);
    chk("bad_err",  64'(ERR),  64'd1);
    chk("bad_clr",  64'(CLR),  64'd0);
    chk("bad_ptn",  64'(PTN),  64'(F1_PTN));
    chk("bad_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    chk("bad_err_end", 64'(ERR), 64'd0);

    // Noise before header is discarded.
    send(8'h00, 1'b0);
    chk("noise00_busy", 64'(BUSY), 64'd0);
    send(8'hFF, 1'b0);
    chk("noiseff_busy", 64'(BUSY), 64'd0);
    send_frame(F2_DAT, F2_CS, 1'b0);
    chk("f2_clr", 64'(CLR), 64'd1);
    chk("f2_ptn", 64'(PTN), 64'(F2_PTN));

    // Abort after three entries, with a header byte offered on the abort edge.
    @(posedge CLK); #1;
    send(8'hA5, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("abort_pre_busy", 64'(BUSY), 64'd1);
    ABORT = 1'b1; DIN = 8'hA5; DIN_VALID = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0; DIN_VALID = 1'b0;
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_clr",  64'(CLR),  64'd0);
    chk("abort_ptn",  64'(PTN),  64'(F2_PTN));
    // Header value inside the frame is plain data.
    send_frame(F3_DAT, F3_CS, 1'b0);
    chk("f3_clr", 64'(CLR), 64'd1);
    chk("f3_ptn", 64'(PTN), 64'(F3_PTN));

    // Reset while waiting for the checksum byte.
    @(posedge CLK); #1;
    send(8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) send(F1_DAT[8*i +: 8], 1'b0);
    chk("chk_busy", 64'(BUSY), 64'd1);
    #2 RST = 1'b1;
    #1;
    chk("arst_ptn",   64'(PTN),       64'd0);
    chk("arst_busy",  64'(BUSY),      64'd0);
    chk("arst_ready", 64'(DIN_READY), 64'd1);
    chk("arst_clr",   64'(CLR),       64'd0);
    chk("arst_err",   64'(ERR),       64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    send_frame(F2_DAT, F2_CS, 1'b0);
    chk("post_rst_clr", 64'(CLR), 64'd1);
    chk("post_rst_ptn", 64'(PTN), 64'(F2_PTN));

    // Back-to-back frames with DIN_VALID held high.
    @(posedge CLK); #1;
    send_frame(F1_DAT, F1_CS, 1'b1);
    chk("b2b1_clr",   64'(CLR),       64'd1);
    chk("b2b1_ptn",   64'(PTN),       64'(F1_PTN));
    chk("b2b1_ready", 64'(DIN_READY), 64'd0);
    send_frame(F2_DAT, F2_CS, 1'b1);
    DIN_VALID = 1'b0;
    chk("b2b_stall",  64'(hdr_stall), 64'd1);
    chk("b2b2_clr",   64'(CLR),       64'd1);
    chk("b2b2_ptn",   64'(PTN),       64'(F2_PTN));
    @(posedge CLK); #1;
    chk("b2b_idle", 64'(BUSY), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
